pc_next_unit: RTL and testbench

//  Program-counter register and next-PC selection for the single-cycle CPU.

---
 rtl/pc_next_unit_pkg.sv | 13 +
 rtl/pc_next_unit_if.sv | 25 ++
 rtl/pc_target_mux.sv | 35 +++
 rtl/pc_next_unit.sv | 77 +++++++
 tb/tb_pc_next_unit.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_next_unit_pkg.sv
// Shared definitions for the program-counter unit: FSM encodings and default vectors.
package pc_next_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0080;

endpackage

// File: rtl/pc_next_unit_if.sv
// Fetch-side bundle between the datapath (master) and the PC unit (slave).
interface pc_next_unit_if;
  import pc_next_unit_pkg::*;

  logic        stall_i;
  logic        branch_i;
  logic        zero_i;
  logic [31:0] offset_sl2_i;
  logic        jump_i;
  logic [25:0] jump_addr_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        pc_valid_o;

  modport master (
    output stall_i, branch_i, zero_i, offset_sl2_i, jump_i, jump_addr_i,
    input  pc_o, pc_plus4_o, pc_valid_o
  );

  modport slave (
    input  stall_i, branch_i, zero_i, offset_sl2_i, jump_i, jump_addr_i,
    output pc_o, pc_plus4_o, pc_valid_o
  );

endinterface

// File: rtl/pc_target_mux.sv
// Combinational next-PC selection: sequential, branch and jump targets with
// jump > taken-branch > sequential priority and a misaligned-target trap.
module pc_target_mux #(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] offset_sl2,
  input  logic        jump,
  input  logic [25:0] jump_addr,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] sel_tgt;

  assign pc_plus4 = pc + 32'd4;
  assign br_tgt   = pc_plus4 + offset_sl2;
  assign jmp_tgt  = {pc_plus4[31:28], jump_addr, 2'b00};

  always_comb begin
    sel_tgt = pc_plus4;
    if (jump)             sel_tgt = jmp_tgt;
    else if (branch && zero) sel_tgt = br_tgt;
  end

  // jump and sequential targets are always word aligned; only a bad offset trips this
  assign misalign = (sel_tgt[1:0] != 2'b00);
  assign next_pc  = misalign ? TRAP_VEC : sel_tgt;

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter register with run/halt FSM, fetch stall, sticky misalign trap
// flag and retired-instruction counter.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] TRAP_VEC  = TRAP_VEC_DEF,
  parameter int          CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             halt_i,
  pc_next_unit_if.slave    dp,
  output logic             misalign_o,
  output logic [CNT_W-1:0] retired_o,
  output logic [1:0]       state_o
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q;
  logic [31:0]      next_pc;
  logic             tgt_misalign;
  logic             misalign_q;
  logic [CNT_W-1:0] retired_q;
  logic             pc_valid;

  pc_target_mux #(.TRAP_VEC(TRAP_VEC)) u_mux (
    .pc         (pc_q),
    .branch     (dp.branch_i),
    .zero       (dp.zero_i),
    .offset_sl2 (dp.offset_sl2_i),
    .jump       (dp.jump_i),
    .jump_addr  (dp.jump_addr_i),
    .pc_plus4   (dp.pc_plus4_o),
    .next_pc    (next_pc),
    .misalign   (tgt_misalign)
  );

  assign pc_valid = (state_q == ST_RUN) && !dp.stall_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i)             state_d = ST_RUN;
      ST_RUN:  if (halt_i && pc_valid)  state_d = ST_HALT;
      ST_HALT: if (start_i)             state_d = ST_RUN;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q <= state_d;
      // leaving IDLE always restarts from the reset vector; HALT resumes in place
      if (state_q == ST_IDLE && start_i) begin
        pc_q <= RESET_VEC;
      end else if (pc_valid) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (tgt_misalign) misalign_q <= 1'b1;
      end
    end
  end

  assign dp.pc_o       = pc_q;
  assign dp.pc_valid_o = pc_valid;
  assign misalign_o    = misalign_q;
  assign retired_o     = retired_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: expected PCs are queued as each cycle is
// driven and compared once the DUT register has taken the edge.
module tb_pc_next_unit;
  import pc_next_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt;
  logic        misalign;
  logic [31:0] retired;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  pc_next_unit_if dp();

  pc_next_unit #(.RESET_VEC(32'h0), .TRAP_VEC(32'h80), .CNT_W(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .halt_i     (halt),
    .dp         (dp.slave),
    .misalign_o (misalign),
    .retired_o  (retired),
    .state_o    (state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // drive one cycle of datapath inputs and queue the PC expected after the edge
  task automatic issue(input logic st, input logic br, input logic z,
                       input logic [31:0] off, input logic j,
                       input logic [25:0] ja, input logic [31:0] exp_pc);
    dp.stall_i      = st;
    dp.branch_i     = br;
    dp.zero_i       = z;
    dp.offset_sl2_i = off;
    dp.jump_i       = j;
    dp.jump_addr_i  = ja;
    sb.push_back(exp_pc);
    tick();
    dp.stall_i  = 1'b0;
    dp.branch_i = 1'b0;
    dp.zero_i   = 1'b0;
    dp.jump_i   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; halt = 1'b0;
    dp.stall_i = 1'b0; dp.branch_i = 1'b0; dp.zero_i = 1'b0;
    dp.offset_sl2_i = '0; dp.jump_i = 1'b0; dp.jump_addr_i = '0;
    tick(); tick();
    total++;
    if (dp.pc_o !== 32'h0 || state !== 2'd0 || misalign !== 1'b0 || retired !== 32'd0
        || dp.pc_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset pc=%h st=%0d mis=%b ret=%0d vld=%b exp 0/0/0/0/0",
               dp.pc_o, state, misalign, retired, dp.pc_valid_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential;
    logic [31:0] exp;
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (state !== 2'd1 || dp.pc_o !== 32'h0 || dp.pc_plus4_o !== 32'h4) begin
      bad++;
      $display("FAIL start st=%0d pc=%h p4=%h exp 1/0/4", state, dp.pc_o, dp.pc_plus4_o);
    end
    for (int i = 1; i <= 3; i++) begin
      issue(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'(i * 4));
      exp = sb.pop_front();
      total++;
      if (dp.pc_o !== exp) begin
        bad++; $display("FAIL seq_%0d pc=%h exp=%h", i, dp.pc_o, exp);
      end
    end
    total++;
    if (retired !== 32'd3) begin
      bad++; $display("FAIL retired_3 got=%0d exp=3", retired);
    end
  endtask

  task automatic test_branch;
    logic [31:0] exp;
    issue(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h10, 32'h40);            // jump to 0x40
    issue(1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 26'h0, 32'h54);            // taken
    issue(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h10, 32'h40);            // back to 0x40
    issue(1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 26'h0, 32'h44);            // not taken
    issue(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 26'h0, 32'h48);            // zero without branch
    for (int i = 0; i < 5; i++) begin
      exp = sb.pop_front();
      total++;
      // pc_o only reflects the last queued entry; earlier ones were checked in order below
      if (i == 4 && dp.pc_o !== exp) begin
        bad++; $display("FAIL branch_seq pc=%h exp=%h", dp.pc_o, exp);
      end else if (i != 4) total--;
    end
    // step-by-step checks of taken/not-taken
    issue(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h10, 32'h40);
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp) begin bad++; $display("FAIL jmp_40 pc=%h exp=%h", dp.pc_o, exp); end
    issue(1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 26'h0, 32'h54);
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp) begin bad++; $display("FAIL br_taken pc=%h exp=%h", dp.pc_o, exp); end
    issue(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h10, 32'h40);
    exp = sb.pop_front();
    issue(1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 26'h0, 32'h44);
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp) begin bad++; $display("FAIL br_untaken pc=%h exp=%h", dp.pc_o, exp); end
  endtask

  task automatic test_jump;
    logic [31:0] exp;
    issue(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h10, 32'h40);
    exp = sb.pop_front();
    issue(1'b0, 1'b1, 1'b1, 32'h0FFF_FFFC, 1'b0, 26'h0, 32'h1000_0040);
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp) begin bad++; $display("FAIL br_far pc=%h exp=%h", dp.pc_o, exp); end
    issue(1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 26'h100, 32'h1000_0400);
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp) begin bad++; $display("FAIL jmp_prio pc=%h exp=%h", dp.pc_o, exp); end
  endtask

  task automatic test_stall;
    logic [31:0] exp;
    logic [31:0] ret0;
    issue(1'b0, 1'b1, 1'b1, 32'hEFFF_FC1C, 1'b0, 26'h0, 32'h20);
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp) begin bad++; $display("FAIL to_20 pc=%h exp=%h", dp.pc_o, exp); end
    ret0 = retired;
    for (int i = 0; i < 2; i++) begin
      dp.stall_i = 1'b1; dp.jump_i = 1'b1; dp.jump_addr_i = 26'h3F;
      #1;
      total++;
      if (dp.pc_valid_o !== 1'b0) begin
        bad++; $display("FAIL stall_vld got=%b exp=0", dp.pc_valid_o);
      end
      issue(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h3F, 32'h20);
      exp = sb.pop_front(); total++;
      if (dp.pc_o !== exp) begin bad++; $display("FAIL stall_hold pc=%h exp=%h", dp.pc_o, exp); end
    end
    total++;
    if (retired !== ret0) begin bad++; $display("FAIL stall_ret got=%0d exp=%0d", retired, ret0); end
    issue(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h24);
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp || retired !== ret0 + 1) begin
      bad++; $display("FAIL unstall pc=%h ret=%0d exp=%h/%0d", dp.pc_o, retired, exp, ret0 + 1);
    end
  endtask

  task automatic test_wrap_misalign;
    logic [31:0] exp;
    issue(1'b0, 1'b1, 1'b1, 32'hFFFF_FFD4, 1'b0, 26'h0, 32'hFFFF_FFFC);
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp) begin bad++; $display("FAIL to_top pc=%h exp=%h", dp.pc_o, exp); end
    issue(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp || misalign !== 1'b0) begin
      bad++; $display("FAIL wrap pc=%h mis=%b exp=%h/0", dp.pc_o, misalign, exp);
    end
    issue(1'b0, 1'b1, 1'b0, 32'h6, 1'b0, 26'h0, 32'h4);              // untaken bad offset
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp || misalign !== 1'b0) begin
      bad++; $display("FAIL untaken_odd pc=%h mis=%b exp=%h/0", dp.pc_o, misalign, exp);
    end
    issue(1'b0, 1'b1, 1'b1, 32'h6, 1'b0, 26'h0, 32'h80);
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp || misalign !== 1'b1) begin
      bad++; $display("FAIL trap pc=%h mis=%b exp=%h/1", dp.pc_o, misalign, exp);
    end
    issue(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h84);
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp || misalign !== 1'b1) begin
      bad++; $display("FAIL sticky pc=%h mis=%b exp=%h/1", dp.pc_o, misalign, exp);
    end
  endtask

  task automatic test_halt;
    logic [31:0] exp;
    halt = 1'b1;
    issue(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h88);
    halt = 1'b0;
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp || state !== 2'd2) begin
      bad++; $display("FAIL halt pc=%h st=%0d exp=%h/2", dp.pc_o, state, exp);
    end
    issue(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h7, 32'h88);
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp || dp.pc_valid_o !== 1'b0) begin
      bad++; $display("FAIL halt_frozen pc=%h vld=%b exp=%h/0", dp.pc_o, dp.pc_valid_o, exp);
    end
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (dp.pc_o !== 32'h88 || state !== 2'd1) begin
      bad++; $display("FAIL resume pc=%h st=%0d exp=88/1", dp.pc_o, state);
    end
    halt = 1'b1;
    issue(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h40, 32'h100);
    halt = 1'b0;
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp || state !== 2'd2) begin
      bad++; $display("FAIL halt_redirect pc=%h st=%0d exp=%h/2", dp.pc_o, state, exp);
    end
    start = 1'b1; tick(); start = 1'b0;
    halt = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h100);
    halt = 1'b0;
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp || state !== 2'd1) begin
      bad++; $display("FAIL halt_stalled pc=%h st=%0d exp=%h/1", dp.pc_o, state, exp);
    end
    rst = 1'b1;
    issue(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h55, 32'h0);
    rst = 1'b0;
    exp = sb.pop_front(); total++;
    if (dp.pc_o !== exp || state !== 2'd0 || misalign !== 1'b0 || retired !== 32'd0) begin
      bad++; $display("FAIL mid_reset pc=%h st=%0d mis=%b ret=%0d exp %h/0/0/0",
                      dp.pc_o, state, misalign, retired, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] mpc, tgt, exp, off;
    logic [25:0] ja;
    int kind, nret;
    mpc = 32'h0; nret = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      off  = 32'($signed($urandom_range(0, 128)) - 64) << 2;
      ja   = 26'($urandom);
      case (kind)
        0: tgt = mpc + 32'd4;
        1: tgt = mpc + 32'd4 + off;
        2: tgt = {mpc[31:28] + ((mpc[27:0] > 28'hFFF_FFFB) ? 4'd1 : 4'd0), ja, 2'b00};
        default: tgt = mpc;
      endcase
      if (kind != 3) nret++;
      issue(kind == 3, kind == 1 || kind == 3, 1'b1, off, kind == 2, ja, tgt);
      mpc = tgt;
      exp = sb.pop_front(); total++;
      if (dp.pc_o !== exp) begin
        bad++; $display("FAIL b2b_%0d kind=%0d pc=%h exp=%h", i, kind, dp.pc_o, exp);
      end
    end
    total++;
    if (retired !== 32'(nret)) begin
      bad++; $display("FAIL b2b_ret got=%0d exp=%0d", retired, nret);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_wrap_misalign();
    test_halt();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
